game_flow_ctrl: RTL and testbench

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

---
 rtl/game_pkg.sv | 40 ++++
 rtl/frame_counter.sv | 34 +++
 rtl/game_flow_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared encodings for the game flow controller and the start menu.
//   - state_t  : flow controller state encoding (ST_PAUSED only with GAME_FLOW_PAUSE_EN)
//   - winner_t : winner codes reported on game_flow_ctrl.winner
//   - mode_t   : locked menu choice codes produced by the start menu
package game_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_MENU      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAY      = 3'd2,
    ST_SERVE     = 3'd3,
    ST_GAME_OVER = 3'd4
`ifdef GAME_FLOW_PAUSE_EN
    ,
    ST_PAUSED    = 3'd5
`endif
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'd0,
    WIN_LEFT  = 2'd1,
    WIN_RIGHT = 2'd2
  } winner_t;

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_1P   = 2'd1,
    MODE_2P   = 2'd2
  } mode_t;

  // States in which the shared frame counter runs.
  function automatic logic is_counting(input state_t s);
    return (s == ST_COUNTDOWN) || (s == ST_SERVE);
  endfunction

endpackage

// File: rtl/frame_counter.sv
// frame_counter: counts tick pulses up to a terminal value, then wraps to 0.
//   clk_0  : clock
//   rst    : synchronous active-low reset
//   clr    : holds the count at 0 (ticks ignored while high)
//   tick   : count enable pulse
//   term   : terminal count (1..255)
//   hit_c  : combinational pulse on the tick that reaches term
module frame_counter
  import game_pkg::*;
(
  input  logic             clk_0,
  input  logic             rst,
  input  logic             clr,
  input  logic             tick,
  input  logic [CNT_W-1:0] term,
  output logic             hit_c
);

  logic [CNT_W-1:0] count;

  assign hit_c = tick && !clr && (count == term - CNT_W'(1));

  // Count register; wraps to 0 on the terminal tick.
  always_ff @(posedge clk_0) begin
    if (!rst) begin
      count <= '0;
    end else if (clr || hit_c) begin
      count <= '0;
    end else if (tick) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level game flow FSM (menu, countdown, play, serve, game over).
// Optional feature macro: GAME_FLOW_PAUSE_EN adds pause_key and the PAUSED state.
// Ports:
//   clk_0, rst (sync active-low)     clock / reset
//   frame_tick                       one pulse per video frame
//   mode_choice[1:0]                 locked menu choice (MODE_NONE/1P/2P)
//   key_any                          level any-key used to leave GAME_OVER
//   point_l, point_r                 score pulses from the ball logic
//   pause_key (macro only)           pause toggle key
//   state[2:0]                       current state encoding
//   menu_active, menu_rst            menu shown / active-low menu clear pulse
//   game_run, ball_reset, ai_en      playfield controls
//   score_l, score_r, winner, cd_digit  scoreboard and countdown display
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int unsigned STEP_FRAMES  = 60,
  parameter int unsigned SERVE_FRAMES = 45,
  parameter int unsigned WIN_SCORE    = 7
) (
  input  logic               clk_0,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic [1:0]         mode_choice,
  input  logic               key_any,
  input  logic               point_l,
  input  logic               point_r,
`ifdef GAME_FLOW_PAUSE_EN
  input  logic               pause_key,
`endif
  output logic [STATE_W-1:0] state,
  output logic               menu_active,
  output logic               menu_rst,
  output logic               game_run,
  output logic               ball_reset,
  output logic               ai_en,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [1:0]         winner,
  output logic [1:0]         cd_digit
);

  localparam logic [CNT_W-1:0]   STEP_T    = CNT_W'(STEP_FRAMES);
  localparam logic [CNT_W-1:0]   SERVE_T   = CNT_W'(SERVE_FRAMES);
  localparam logic [SCORE_W-1:0] WIN_T     = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t             cur_st, nxt_st;
  logic               key_q, mrst_d;
  logic               ma_nxt, mrst_nxt, run_nxt, bres_nxt, ai_nxt;
  logic [SCORE_W-1:0] sl_nxt, sr_nxt;
  logic [1:0]         win_nxt, cd_nxt;
  logic               hit_c, cnt_clr_c, key_rise_c, mode_ok_c;
  logic [CNT_W-1:0]   cnt_term_c;

  // Counter is held clear outside COUNTDOWN/SERVE, so a tick on the entry edge is dropped.
  assign cnt_clr_c  = !is_counting(cur_st);
  assign cnt_term_c = (cur_st == ST_SERVE) ? SERVE_T : STEP_T;
  assign key_rise_c = key_any && !key_q;
  // Menu choice is blocked while menu_rst is low and for the cycle after.
  assign mode_ok_c  = menu_rst && mrst_d;
  assign state      = cur_st;

  frame_counter u_frame_counter (
    .clk_0 (clk_0),
    .rst   (rst),
    .clr   (cnt_clr_c),
    .tick  (frame_tick),
    .term  (cnt_term_c),
    .hit_c (hit_c)
  );

`ifdef GAME_FLOW_PAUSE_EN
  logic pause_q, pause_rise_c;
  assign pause_rise_c = pause_key && !pause_q;

  always_ff @(posedge clk_0) begin
    if (!rst) pause_q <= 1'b0;
    else      pause_q <= pause_key;
  end
`endif

  // Next-state and next-output logic.
  always_comb begin
    nxt_st   = cur_st;
    ai_nxt   = ai_en;
    sl_nxt   = score_l;
    sr_nxt   = score_r;
    win_nxt  = winner;
    cd_nxt   = cd_digit;
    mrst_nxt = 1'b1;

    case (cur_st)
      ST_MENU: begin
        if (mode_ok_c && (mode_choice == MODE_1P || mode_choice == MODE_2P)) begin
          ai_nxt = (mode_choice == MODE_1P);
          sl_nxt = '0;
          sr_nxt = '0;
          cd_nxt = 2'd3;
          nxt_st = ST_COUNTDOWN;
        end
      end
      ST_COUNTDOWN: begin
        if (hit_c) begin
          if (cd_digit == 2'd1) begin
            cd_nxt = 2'd0;
            nxt_st = ST_PLAY;
          end else begin
            cd_nxt = cd_digit - 2'd1;
          end
        end
      end
      ST_PLAY: begin
        // point_l wins a simultaneous point.
        if (point_l) begin
          if (score_l != SCORE_MAX) sl_nxt = score_l + SCORE_W'(1);
          if (sl_nxt == WIN_T) begin
            win_nxt = WIN_LEFT;
            nxt_st  = ST_GAME_OVER;
          end else begin
            nxt_st  = ST_SERVE;
          end
        end else if (point_r) begin
          if (score_r != SCORE_MAX) sr_nxt = score_r + SCORE_W'(1);
          if (sr_nxt == WIN_T) begin
            win_nxt = WIN_RIGHT;
            nxt_st  = ST_GAME_OVER;
          end else begin
            nxt_st  = ST_SERVE;
          end
        end
`ifdef GAME_FLOW_PAUSE_EN
        else if (pause_rise_c) begin
          nxt_st = ST_PAUSED;
        end
`endif
      end
      ST_SERVE: begin
        if (hit_c) nxt_st = ST_PLAY;
      end
      ST_GAME_OVER: begin
        // Edge detect means a key already held on entry must be released first.
        if (key_rise_c) begin
          mrst_nxt = 1'b0;
          win_nxt  = WIN_NONE;
          nxt_st   = ST_MENU;
        end
      end
`ifdef GAME_FLOW_PAUSE_EN
      ST_PAUSED: begin
        if (pause_rise_c) nxt_st = ST_PLAY;
      end
`endif
      default: nxt_st = ST_MENU;
    endcase

    ma_nxt   = (nxt_st == ST_MENU);
    run_nxt  = (nxt_st == ST_PLAY);
    bres_nxt = (nxt_st != ST_PLAY);
`ifdef GAME_FLOW_PAUSE_EN
    if (nxt_st == ST_PAUSED) bres_nxt = 1'b0;
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clk_0) begin
    if (!rst) begin
      cur_st      <= ST_MENU;
      menu_active <= 1'b1;
      menu_rst    <= 1'b0;
      game_run    <= 1'b0;
      ball_reset  <= 1'b1;
      ai_en       <= 1'b0;
      score_l     <= '0;
      score_r     <= '0;
      winner      <= WIN_NONE;
      cd_digit    <= 2'd0;
      key_q       <= 1'b0;
      mrst_d      <= 1'b0;
    end else begin
      cur_st      <= nxt_st;
      menu_active <= ma_nxt;
      menu_rst    <= mrst_nxt;
      game_run    <= run_nxt;
      ball_reset  <= bres_nxt;
      ai_en       <= ai_nxt;
      score_l     <= sl_nxt;
      score_r     <= sr_nxt;
      winner      <= win_nxt;
      cd_digit    <= cd_nxt;
      key_q       <= key_any;
      mrst_d      <= menu_rst;
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: scoreboard bench for game_flow_ctrl.
// Instance A: defaults with WIN_SCORE=3. Instance B: short timers, WIN_SCORE=7.
module tb_game_flow_ctrl;
  import game_pkg::*;

  logic clk_0 = 1'b0;
  always #5 clk_0 = ~clk_0;

  // Instance A stimulus / outputs
  logic       rst = 1'b0, frame_tick = 1'b0, key_any = 1'b0, point_l = 1'b0, point_r = 1'b0;
  logic [1:0] mode_choice = 2'd0;
  logic [2:0] a_st;
  logic       a_ma, a_mr, a_gr, a_br, a_ai;
  logic [3:0] a_sl, a_sr;
  logic [1:0] a_w, a_cd;

  // Instance B stimulus / outputs
  logic       b_rst = 1'b0, b_tick = 1'b0, b_key = 1'b0, b_pl = 1'b0, b_pr = 1'b0;
  logic [1:0] b_mode = 2'd0;
  logic [2:0] b_st;
  logic       b_ma, b_mr, b_gr, b_br, b_ai;
  logic [3:0] b_sl, b_sr;
  logic [1:0] b_w, b_cd;

  game_flow_ctrl #(.STEP_FRAMES(60), .SERVE_FRAMES(45), .WIN_SCORE(3)) u_dut_a (
    .clk_0(clk_0), .rst(rst), .frame_tick(frame_tick), .mode_choice(mode_choice),
    .key_any(key_any), .point_l(point_l), .point_r(point_r),
    .state(a_st), .menu_active(a_ma), .menu_rst(a_mr), .game_run(a_gr),
    .ball_reset(a_br), .ai_en(a_ai), .score_l(a_sl), .score_r(a_sr),
    .winner(a_w), .cd_digit(a_cd)
  );

  game_flow_ctrl #(.STEP_FRAMES(2), .SERVE_FRAMES(3), .WIN_SCORE(7)) u_dut_b (
    .clk_0(clk_0), .rst(b_rst), .frame_tick(b_tick), .mode_choice(b_mode),
    .key_any(b_key), .point_l(b_pl), .point_r(b_pr),
    .state(b_st), .menu_active(b_ma), .menu_rst(b_mr), .game_run(b_gr),
    .ball_reset(b_br), .ai_en(b_ai), .score_l(b_sl), .score_r(b_sr),
    .winner(b_w), .cd_digit(b_cd)
  );

  wire [19:0] snap_a = {a_st, a_ma, a_mr, a_gr, a_br, a_ai, a_sl, a_sr, a_w, a_cd};
  wire [19:0] snap_b = {b_st, b_ma, b_mr, b_gr, b_br, b_ai, b_sl, b_sr, b_w, b_cd};

  typedef struct {
    int         cyc;
    bit         dut;
    string      tag;
    logic [19:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk_0) cyc <= cyc + 1;

  // Monitor: compare every expectation stamped for the current cycle.
  exp_t        mon_e;
  logic [19:0] mon_act;
  always @(negedge clk_0) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e   = sb.pop_front();
      mon_act = mon_e.dut ? snap_b : snap_a;
      checks++;
      if (mon_e.cyc != cyc || mon_act !== mon_e.val) begin
        errors++;
        $display("FAIL %s (dut %s, cyc %0d): got {st,ma,mrst,run,brst,ai,sl,sr,w,cd}=%05h, want %05h",
                 mon_e.tag, mon_e.dut ? "B" : "A", cyc, mon_act, mon_e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_0);
    #1;
  endtask

  // Expected outputs of a state; menu_active/game_run/ball_reset follow the state.
  task automatic push_exp(input bit sel, input string tag, input state_t st, input logic ai,
                          input logic [3:0] sl, input logic [3:0] sr, input logic [1:0] w,
                          input logic [1:0] cd, input logic mrst);
    exp_t e;
    e.cyc = cyc;
    e.dut = sel;
    e.tag = tag;
    e.val = {st, st == ST_MENU, mrst, st == ST_PLAY, st != ST_PLAY, ai, sl, sr, w, cd};
    sb.push_back(e);
  endtask

  task automatic ticks(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel) b_tick = 1'b1; else frame_tick = 1'b1;
      step();
      b_tick = 1'b0;
      frame_tick = 1'b0;
      step();
    end
  endtask

  initial begin
    // Reset both instances
    step(); step(); step();
    push_exp(0, "reset_a", ST_MENU, 0, 0, 0, 0, 0, 0);
    push_exp(1, "reset_b", ST_MENU, 0, 0, 0, 0, 0, 0);

    // Mode choice held across release: blocked for two cycles, then accepted
    rst = 1'b1; b_rst = 1'b1; mode_choice = 2'd1;
    step(); push_exp(0, "release", ST_MENU, 0, 0, 0, 0, 0, 1);
    step(); push_exp(0, "mode_guard", ST_MENU, 0, 0, 0, 0, 0, 1);
    frame_tick = 1'b1;   // tick on the entry edge must not count
    step(); push_exp(0, "mode_1p", ST_COUNTDOWN, 1, 0, 0, 0, 3, 1);
    mode_choice = 2'd0; frame_tick = 1'b0;

    // Countdown 3/2/1, 60 ticks each
    ticks(0, 59); push_exp(0, "cd3_hold", ST_COUNTDOWN, 1, 0, 0, 0, 3, 1);
    ticks(0, 1);  push_exp(0, "cd2", ST_COUNTDOWN, 1, 0, 0, 0, 2, 1);
    ticks(0, 59); push_exp(0, "cd2_hold", ST_COUNTDOWN, 1, 0, 0, 0, 2, 1);
    ticks(0, 1);  push_exp(0, "cd1", ST_COUNTDOWN, 1, 0, 0, 0, 1, 1);
    ticks(0, 59); push_exp(0, "cd1_hold", ST_COUNTDOWN, 1, 0, 0, 0, 1, 1);
    ticks(0, 1);  push_exp(0, "play", ST_PLAY, 1, 0, 0, 0, 0, 1);

    // point_r -> SERVE for 45 ticks, point outside PLAY ignored
    point_r = 1'b1; step(); point_r = 1'b0;
    push_exp(0, "point_r", ST_SERVE, 1, 0, 1, 0, 0, 1);
    point_l = 1'b1; step(); point_l = 1'b0;
    push_exp(0, "serve_ignore_pt", ST_SERVE, 1, 0, 1, 0, 0, 1);
    ticks(0, 44); push_exp(0, "serve_hold", ST_SERVE, 1, 0, 1, 0, 0, 1);
    ticks(0, 1);  push_exp(0, "serve_end", ST_PLAY, 1, 0, 1, 0, 0, 1);

    // Simultaneous points: only point_l counts
    point_l = 1'b1; point_r = 1'b1; step(); point_l = 1'b0; point_r = 1'b0;
    push_exp(0, "both_pts", ST_SERVE, 1, 1, 1, 0, 0, 1);
    ticks(0, 45); push_exp(0, "serve2_end", ST_PLAY, 1, 1, 1, 0, 0, 1);
    point_l = 1'b1; step(); point_l = 1'b0;
    push_exp(0, "point_l2", ST_SERVE, 1, 2, 1, 0, 0, 1);
    ticks(0, 45); push_exp(0, "serve3_end", ST_PLAY, 1, 2, 1, 0, 0, 1);

    // Win with key_any already held
    key_any = 1'b1; step();
    push_exp(0, "key_in_play", ST_PLAY, 1, 2, 1, 0, 0, 1);
    point_l = 1'b1; step(); point_l = 1'b0;
    push_exp(0, "win_left", ST_GAME_OVER, 1, 3, 1, 1, 0, 1);
    point_l = 1'b1; point_r = 1'b1; step(); point_l = 1'b0; point_r = 1'b0;
    push_exp(0, "go_ignore_pts", ST_GAME_OVER, 1, 3, 1, 1, 0, 1);
    step(); step(); step();
    push_exp(0, "go_key_held", ST_GAME_OVER, 1, 3, 1, 1, 0, 1);
    key_any = 1'b0; step();
    push_exp(0, "go_key_release", ST_GAME_OVER, 1, 3, 1, 1, 0, 1);
    key_any = 1'b1; step();
    push_exp(0, "go_exit", ST_MENU, 1, 3, 1, 0, 0, 0);
    mode_choice = 2'd2;
    step(); push_exp(0, "menu_rst_pulse_end", ST_MENU, 1, 3, 1, 0, 0, 1);
    step(); push_exp(0, "menu_guard2", ST_MENU, 1, 3, 1, 0, 0, 1);
    step(); push_exp(0, "mode_2p", ST_COUNTDOWN, 0, 0, 0, 0, 3, 1);
    mode_choice = 2'd0; key_any = 1'b0;

    // Abort from COUNTDOWN
    ticks(0, 10);
    rst = 1'b0; step();
    push_exp(0, "rst_countdown", ST_MENU, 0, 0, 0, 0, 0, 0);
    rst = 1'b1; step();
    push_exp(0, "rst_countdown_rel", ST_MENU, 0, 0, 0, 0, 0, 1);

    // Instance B: reach SERVE with score_l=5, then reset
    b_mode = 2'd2; step(); b_mode = 2'd0;
    push_exp(1, "b_mode_2p", ST_COUNTDOWN, 0, 0, 0, 0, 3, 1);
    ticks(1, 2); push_exp(1, "b_cd2", ST_COUNTDOWN, 0, 0, 0, 0, 2, 1);
    ticks(1, 2); push_exp(1, "b_cd1", ST_COUNTDOWN, 0, 0, 0, 0, 1, 1);
    ticks(1, 2); push_exp(1, "b_play", ST_PLAY, 0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 5; k++) begin
      b_pl = 1'b1; step(); b_pl = 1'b0;
      push_exp(1, "b_point_l", ST_SERVE, 0, 4'(k), 0, 0, 0, 1);
      if (k < 5) begin
        ticks(1, 3);
        push_exp(1, "b_serve_end", ST_PLAY, 0, 4'(k), 0, 0, 0, 1);
      end
    end
    ticks(1, 1); push_exp(1, "b_serve_mid", ST_SERVE, 0, 5, 0, 0, 0, 1);
    b_rst = 1'b0; step();
    push_exp(1, "b_rst_serve", ST_MENU, 0, 0, 0, 0, 0, 0);
    b_rst = 1'b1; step();
    push_exp(1, "b_rst_rel", ST_MENU, 0, 0, 0, 0, 0, 1);

    step(); step();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
